// File: rtl/clk_gen_multi_if.sv
// clk_gen_multi_if: enable, configuration and generated-clock bundle of clk_gen_multi.
interface clk_gen_multi_if #(parameter int NUM_CH = 4, parameter int CNT_W = 16);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_high;
  logic [CNT_W-1:0]  cfg_phase;
  logic              cfg_ack;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] ch_active;
  logic [NUM_CH-1:0] sync_pulse;
  modport master (
    output ch_en, cfg_wr, cfg_ch, cfg_period, cfg_high, cfg_phase,
    input  cfg_ack, cfg_err, clk_out, ch_active, sync_pulse
  );
  modport slave (
    input  ch_en, cfg_wr, cfg_ch, cfg_period, cfg_high, cfg_phase,
    output cfg_ack, cfg_err, clk_out, ch_active, sync_pulse
  );
endinterface

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: N-channel clock generator with run-time period/high/phase per channel,
// glitch-free start/stop, and settings that only take effect on period boundaries.
module clk_gen_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
) (
  input logic            clk,
  input logic            rst_n,
  clk_gen_multi_if.slave bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {IDLE, PHASE, RUN} state_t;
  logic wr_ok, ack_q, err_q;
  assign wr_ok = bus.cfg_wr && int'(bus.cfg_ch) < NUM_CH && bus.cfg_period >= CNT_W'(2) &&
                 bus.cfg_high >= ONE && bus.cfg_high <= bus.cfg_period - ONE &&
                 bus.cfg_phase <= bus.cfg_period - ONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= wr_ok;
      err_q <= bus.cfg_wr && !wr_ok;
    end
  assign bus.cfg_ack = ack_q;
  assign bus.cfg_err = err_q;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, hi_q, ph_q, pper_q, phi_q, pph_q, e_ph;
    logic             pv_q, apply, wr_me, clk_q, clk_d, act_q, act_d, sync_q, sync_d;
    assign wr_me = wr_ok && bus.cfg_ch == CH_W'(c);
    // An idle channel starts with its pending settings if a write is waiting.
    assign e_ph = pv_q ? pph_q : ph_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        per_q  <= CNT_W'(DEF_PERIOD);
        hi_q   <= CNT_W'(DEF_HIGH);
        ph_q   <= '0;
        pper_q <= '0;
        phi_q  <= '0;
        pph_q  <= '0;
        pv_q   <= 1'b0;
        clk_q  <= 1'b0;
        act_q  <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        clk_q  <= clk_d;
        act_q  <= act_d;
        sync_q <= sync_d;
        if (apply) begin
          per_q <= pper_q;
          hi_q  <= phi_q;
          ph_q  <= pph_q;
        end
        if (wr_me) begin
          pper_q <= bus.cfg_period;
          phi_q  <= bus.cfg_high;
          pph_q  <= bus.cfg_phase;
        end
        pv_q <= wr_me || (pv_q && !apply);
      end
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q + ONE;
      apply = 1'b0;
      case (st_q)
        IDLE: begin
          apply = pv_q;
          st_d  = !bus.ch_en[c] ? IDLE : (e_ph == '0 ? RUN : PHASE);
          cnt_d = e_ph == '0 ? '0 : e_ph - ONE;
        end
        PHASE: begin
          st_d  = !bus.ch_en[c] ? IDLE : (cnt_q == '0 ? RUN : PHASE);
          cnt_d = cnt_q == '0 ? '0 : cnt_q - ONE;
        end
        RUN: if (cnt_q == per_q - ONE) begin
          st_d  = bus.ch_en[c] ? RUN : IDLE;
          cnt_d = '0;
          apply = bus.ch_en[c] && pv_q;
        end
        default: st_d = IDLE;
      endcase
    end
    always_comb begin
      clk_d  = st_q == RUN && cnt_q < hi_q;
      sync_d = st_q == RUN && cnt_q == '0;
      act_d  = st_q != IDLE;
    end
    assign bus.clk_out[c]    = clk_q;
    assign bus.ch_active[c]  = act_q;
    assign bus.sync_pulse[c] = sync_q;
  end
endmodule
